// File: rtl/ctrl_multiciclo_if.sv
// Control bundle between the multicycle controller and the 8-bit datapath/memories.
// The controller drives the master modport. The datapath and memories use the slave modport.
interface ctrl_multiciclo_if #(
  parameter int CNT_W = 16
);
  // Request/ready: imem_req and memRead/memWrite stay high, with stable
  // operands, until the matching ready is sampled high on a rising edge.
  // That edge completes the transfer. A ready seen while nothing is
  // requested is ignored.
  logic             run;
  logic [3:0]       InstCode;
  logic             imem_ready;
  logic             dmem_ready;
  logic             imem_req;
  logic             ir_write;
  logic             pc_inc;
  logic             jump;
  logic             beq;
  logic [2:0]       ULAop;
  logic             ULAsrc;
  logic             atr;
  logic             memRead;
  logic             memWrite;
  logic             memtoReg;
  logic             regWrite;
  logic             halted;
  logic             err;
  logic [CNT_W-1:0] instr_cnt;
  logic [2:0]       state_dbg;

  modport master (
    input  run, InstCode, imem_ready, dmem_ready,
    output imem_req, ir_write, pc_inc, jump, beq, ULAop, ULAsrc, atr,
           memRead, memWrite, memtoReg, regWrite, halted, err,
           instr_cnt, state_dbg
  );

  modport slave (
    output run, InstCode, imem_ready, dmem_ready,
    input  imem_req, ir_write, pc_inc, jump, beq, ULAop, ULAsrc, atr,
           memRead, memWrite, memtoReg, regWrite, halted, err,
           instr_cnt, state_dbg
  );
endinterface

// File: rtl/ctrl_multiciclo.sv
// Multicycle control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with memory
// wait timeout, HALT, ERROR and a retired-instruction counter.
module ctrl_multiciclo #(
  parameter int WAIT_MAX = 15,
  parameter int WAIT_W   = 4,
  parameter int CNT_W    = 16
) (
  input  logic              clock,
  input  logic              reset,
  ctrl_multiciclo_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_ERROR  = 3'd7
  } state_t;

  localparam logic [3:0] OP_LW   = 4'b1001;
  localparam logic [3:0] OP_SW   = 4'b1010;
  localparam logic [3:0] OP_HALT = 4'b1100;

  state_t             state, state_n;
  logic [3:0]         opcode;
  logic [WAIT_W-1:0]  wcnt;
  logic [CNT_W-1:0]   cnt;
  logic               timeout;
  logic               retire;

  // {ULAop, ULAsrc, atr} for an opcode; reused by EXEC, MEM and WB so the ULA
  // inputs stay stable for the whole instruction.
  function automatic logic [4:0] ula_ctl(input logic [3:0] op);
    logic [4:0] r;
    r = 5'b000_0_0;
    casez (op)
      4'b01??: r = 5'b100_0_0;
      4'b1011: r = 5'b010_0_0;
      4'b1101: r = 5'b000_1_0;
      4'b1110: r = 5'b001_1_1;
      4'b1111: r = 5'b011_1_0;
      default: r = 5'b000_0_0;
    endcase
    return r;
  endfunction

  assign timeout = (wcnt == WAIT_W'(WAIT_MAX - 1));
  assign retire  = (state_n == S_FETCH) &&
                   (state == S_EXEC || state == S_MEM || state == S_WB);

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= S_IDLE;
      opcode <= 4'b0000;
      wcnt   <= '0;
      cnt    <= '0;
    end else begin
      state <= state_n;
      if (state == S_DECODE)
        opcode <= bus.InstCode;
      // Any state change clears the counter, so entering FETCH or MEM starts at zero.
      if (state_n != state)
        wcnt <= '0;
      else if (state == S_FETCH || state == S_MEM)
        wcnt <= wcnt + WAIT_W'(1);
      if (retire)
        cnt <= cnt + CNT_W'(1);
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:   if (bus.run) state_n = S_FETCH;
      S_FETCH: begin
        if (bus.imem_ready)  state_n = S_DECODE;
        else if (timeout)    state_n = S_ERROR;
      end
      // DECODE steers on the live opcode, because the register loads on this same edge.
      S_DECODE: state_n = (bus.InstCode == OP_HALT) ? S_HALT : S_EXEC;
      S_EXEC: begin
        if (opcode[3] == 1'b0)                       state_n = S_FETCH;
        else if (opcode == OP_LW || opcode == OP_SW) state_n = S_MEM;
        else if (opcode == OP_HALT)                  state_n = S_HALT;
        else                                         state_n = S_WB;
      end
      S_MEM: begin
        if (bus.dmem_ready) state_n = (opcode == OP_LW) ? S_WB : S_FETCH;
        else if (timeout)   state_n = S_ERROR;
      end
      S_WB:     state_n = S_FETCH;
      S_HALT:   state_n = S_HALT;
      S_ERROR:  state_n = S_ERROR;
      default:  state_n = S_IDLE;
    endcase
  end

  always_comb begin
    bus.imem_req = 1'b0;
    bus.ir_write = 1'b0;
    bus.pc_inc   = 1'b0;
    bus.jump     = 1'b0;
    bus.beq      = 1'b0;
    bus.ULAop    = 3'b000;
    bus.ULAsrc   = 1'b0;
    bus.atr      = 1'b0;
    bus.memRead  = 1'b0;
    bus.memWrite = 1'b0;
    bus.memtoReg = 1'b0;
    bus.regWrite = 1'b0;
    bus.halted   = 1'b0;
    bus.err      = 1'b0;
    case (state)
      S_FETCH: begin
        bus.imem_req = 1'b1;
        bus.ir_write = bus.imem_ready;
        bus.pc_inc   = bus.imem_ready;
      end
      S_EXEC: begin
        {bus.ULAop, bus.ULAsrc, bus.atr} = ula_ctl(opcode);
        bus.jump = (opcode[3:2] == 2'b00);
        bus.beq  = (opcode[3:2] == 2'b01);
      end
      S_MEM: begin
        {bus.ULAop, bus.ULAsrc, bus.atr} = ula_ctl(opcode);
        bus.memRead  = (opcode == OP_LW);
        bus.memWrite = (opcode == OP_SW);
      end
      S_WB: begin
        {bus.ULAop, bus.ULAsrc, bus.atr} = ula_ctl(opcode);
        bus.regWrite = 1'b1;
        bus.memtoReg = (opcode == OP_LW);
      end
      S_HALT:  bus.halted = 1'b1;
      S_ERROR: bus.err    = 1'b1;
      default: ;
    endcase
  end

  assign bus.instr_cnt = cnt;
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_ctrl_multiciclo.sv
// Directed bench for ctrl_multiciclo: instruction sequencing, wait timeout,
// HALT, reset mid-access and counter wrap on a narrow-counter instance.
module tb_ctrl_multiciclo;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_MEM    = 3'd4;
  localparam logic [2:0] ST_WB     = 3'd5;
  localparam logic [2:0] ST_HALT   = 3'd6;
  localparam logic [2:0] ST_ERROR  = 3'd7;

  // clock / reset
  logic clock  = 1'b0;
  logic reset  = 1'b1;
  logic reset2 = 1'b1;
  always #5 clock = ~clock;

  ctrl_multiciclo_if #(.CNT_W(16)) u_if ();
  ctrl_multiciclo #(.WAIT_MAX(15), .WAIT_W(4), .CNT_W(16)) u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (u_if.master)
  );

  ctrl_multiciclo_if #(.CNT_W(2)) u_if2 ();
  ctrl_multiciclo #(.WAIT_MAX(15), .WAIT_W(4), .CNT_W(2)) u_dut2 (
    .clock (clock),
    .reset (reset2),
    .bus   (u_if2.master)
  );

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic drive(input logic r, input logic [3:0] op, input logic ir, input logic dr);
    u_if.run        = r;
    u_if.InstCode   = op;
    u_if.imem_ready = ir;
    u_if.dmem_ready = dr;
    #1;
  endtask

  function automatic logic [13:0] strobes();
    return {u_if.imem_req, u_if.ir_write, u_if.pc_inc, u_if.jump, u_if.beq,
            u_if.ULAop, u_if.ULAsrc, u_if.atr, u_if.memRead, u_if.memWrite,
            u_if.memtoReg, u_if.regWrite};
  endfunction

  initial begin
    logic [31:0] exp;
    int          rd_cnt;
    logic        wr_seen;
    int          halt_ok;

    u_if2.run = 1'b0; u_if2.InstCode = 4'b0000;
    u_if2.imem_ready = 1'b1; u_if2.dmem_ready = 1'b1;
    drive(1'b0, 4'b1000, 1'b1, 1'b1);

    // reset state
    reset = 1'b1;
    tick(); tick();
    check("rst_state", u_if.state_dbg, ST_IDLE);
    check("rst_strobes", strobes(), 14'd0);
    check("rst_flags", {u_if.halted, u_if.err}, 2'b00);
    check("rst_cnt", u_if.instr_cnt, 16'd0);
    reset = 1'b0;
    u_if.run = 1'b1; #1;
    check("idle_strobes", strobes(), 14'd0);

    // ADD: FETCH, DECODE, EXEC, WB, back to FETCH
    exp_q.push_back(32'(ST_FETCH));
    exp_q.push_back(32'(ST_DECODE));
    exp_q.push_back(32'(ST_EXEC));
    exp_q.push_back(32'(ST_WB));
    exp_q.push_back(32'(ST_FETCH));
    while (exp_q.size() > 0) begin
      tick();
      exp = exp_q.pop_front();
      check("add_seq", u_if.state_dbg, exp);
      if (exp == 32'(ST_EXEC))
        check("add_exec", {u_if.ULAop, u_if.ULAsrc, u_if.atr, u_if.regWrite}, 6'b000_0_0_0);
      if (exp == 32'(ST_WB))
        check("add_wb", {u_if.regWrite, u_if.memtoReg}, 2'b10);
    end
    check("add_cnt", u_if.instr_cnt, 16'd1);

    // LW with dmem_ready low for 3 MEM cycles
    u_if.InstCode = 4'b1001; u_if.dmem_ready = 1'b0; #1;
    check("fetch_strobes", {u_if.imem_req, u_if.ir_write, u_if.pc_inc}, 3'b111);
    tick(); tick();
    check("lw_exec", {u_if.state_dbg, u_if.memRead}, {ST_EXEC, 1'b0});
    tick();
    rd_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      u_if.dmem_ready = (i >= 3); #1;
      if (u_if.state_dbg != ST_MEM) break;
      rd_cnt += int'(u_if.memRead);
      tick();
    end
    check("lw_rd_cycles", rd_cnt, 4);
    check("lw_wb", {u_if.state_dbg, u_if.regWrite, u_if.memtoReg, u_if.memRead},
          {ST_WB, 1'b1, 1'b1, 1'b0});
    tick();
    check("lw_cnt", u_if.instr_cnt, 16'd2);

    // SW: memWrite, no WB
    u_if.InstCode = 4'b1010; u_if.dmem_ready = 1'b1; #1;
    wr_seen = 1'b0;
    tick(); wr_seen |= u_if.regWrite;
    tick(); wr_seen |= u_if.regWrite;
    tick(); wr_seen |= u_if.regWrite;
    check("sw_mem", {u_if.state_dbg, u_if.memWrite, u_if.memRead}, {ST_MEM, 1'b1, 1'b0});
    tick(); wr_seen |= u_if.regWrite;
    check("sw_back", {u_if.state_dbg, u_if.memWrite}, {ST_FETCH, 1'b0});
    check("sw_no_regwrite", wr_seen, 1'b0);
    check("sw_cnt", u_if.instr_cnt, 16'd3);

    // J 0011
    u_if.InstCode = 4'b0011; #1;
    tick(); tick();
    check("j_exec", {u_if.jump, u_if.beq}, 2'b10);
    tick();
    check("j_back", {u_if.state_dbg, u_if.jump}, {ST_FETCH, 1'b0});
    check("j_cnt", u_if.instr_cnt, 16'd4);

    // BEQ 0110
    u_if.InstCode = 4'b0110; #1;
    tick(); tick();
    check("beq_exec", {u_if.ULAop, u_if.jump, u_if.beq}, 5'b100_0_1);
    tick();
    check("beq_back", u_if.state_dbg, ST_FETCH);
    check("beq_cnt", u_if.instr_cnt, 16'd5);

    // ATR 1110: ULA controls held through WB
    u_if.InstCode = 4'b1110; #1;
    tick(); tick();
    check("atr_exec", {u_if.ULAop, u_if.ULAsrc, u_if.atr}, 5'b001_1_1);
    tick();
    check("atr_wb", {u_if.ULAop, u_if.ULAsrc, u_if.atr, u_if.regWrite, u_if.memtoReg},
          7'b001_1_1_1_0);
    tick();
    check("atr_cnt", u_if.instr_cnt, 16'd6);

    // SLL 1111 with run dropped mid-program
    u_if.InstCode = 4'b1111; u_if.run = 1'b0; #1;
    tick(); tick();
    check("sll_exec", {u_if.ULAop, u_if.ULAsrc, u_if.atr}, 5'b011_1_0);
    tick(); tick();
    check("sll_back", u_if.state_dbg, ST_FETCH);
    check("sll_cnt", u_if.instr_cnt, 16'd7);

    // imem_ready arriving on the 15th FETCH cycle still advances
    u_if.InstCode = 4'b0011; u_if.imem_ready = 1'b0; #1;
    repeat (14) tick();
    u_if.imem_ready = 1'b1; #1;
    check("to15_irw", u_if.ir_write, 1'b1);
    tick();
    check("to15_decode", {u_if.state_dbg, u_if.err}, {ST_DECODE, 1'b0});
    tick(); tick();
    check("to15_cnt", u_if.instr_cnt, 16'd8);

    // imem_ready never arrives -> ERROR after 15 cycles
    u_if.imem_ready = 1'b0; #1;
    repeat (14) tick();
    check("to_14", {u_if.state_dbg, u_if.err}, {ST_FETCH, 1'b0});
    tick();
    check("to_error", {u_if.state_dbg, u_if.err}, {ST_ERROR, 1'b1});
    check("to_strobes", strobes(), 14'd0);
    u_if.imem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      u_if.run = i[0];
      tick();
    end
    check("err_sticky", {u_if.state_dbg, u_if.err}, {ST_ERROR, 1'b1});

    // HALT
    reset = 1'b1; tick(); reset = 1'b0;
    check("halt_rst", {u_if.state_dbg, u_if.err, u_if.instr_cnt}, {ST_IDLE, 1'b0, 16'd0});
    drive(1'b1, 4'b1100, 1'b1, 1'b1);
    tick(); tick(); tick();
    check("halt_enter", {u_if.state_dbg, u_if.halted}, {ST_HALT, 1'b1});
    halt_ok = 0;
    for (int i = 0; i < 20; i++) begin
      u_if.run = i[0];
      tick();
      if (u_if.halted && u_if.state_dbg == ST_HALT && strobes() == 14'd0) halt_ok++;
    end
    check("halt_sticky", halt_ok, 20);
    check("halt_cnt", u_if.instr_cnt, 16'd0);

    // reset in the middle of a SW access
    reset = 1'b1; tick(); reset = 1'b0;
    drive(1'b1, 4'b1010, 1'b1, 1'b0);
    tick(); tick(); tick(); tick();
    check("swr_mem", {u_if.state_dbg, u_if.memWrite}, {ST_MEM, 1'b1});
    reset = 1'b1;
    tick();
    check("swr_reset", {u_if.state_dbg, u_if.memWrite, u_if.instr_cnt}, {ST_IDLE, 1'b0, 16'd0});
    reset = 1'b0;

    // counter wrap on the 2-bit instance
    reset2 = 1'b1; tick(); reset2 = 1'b0;
    u_if2.run = 1'b1;
    tick();
    repeat (9) tick();
    check("wrap_3", u_if2.instr_cnt, 2'd3);
    repeat (3) tick();
    check("wrap_0", {u_if2.state_dbg, u_if2.instr_cnt}, {ST_FETCH, 2'd0});

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
